// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the core in reset, runs it against a cycle budget,
// and latches the end-of-test mailbox outcome (pass / fail / timeout) until restarted.
module sim_run_ctrl #(
  parameter int                RST_CYCLES  = 4,
  parameter int                MAX_CYCLES  = 100,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int                LED_W       = 4,
  parameter int                CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [LED_W-1:0]  led_in,
  output logic              core_rst,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [LED_W-1:0]  led_snap
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(32'd1);

  logic [1:0]        state_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic [1:0]        state_s;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic              core_rst_s;
  logic              done_s;
  logic              pass_s;
  logic              fail_s;
  logic              timeout_s;
  logic [DATA_W-1:0] exit_code_s;
  logic [CNT_W-1:0]  cycle_cnt_s;
  logic [LED_W-1:0]  led_snap_s;
  logic              hit_s;
  logic              go_hold_s;

  // A zero write is not a result; only non-zero stores to the mailbox end the run.
  assign hit_s = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != {DATA_W{1'b0}});
  assign go_hold_s = restart && ((state_r == ST_RUN) || (state_r == ST_END));

  // Next-state and next-output computation for the hold/run/end sequencer.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    core_rst_s  = core_rst;
    done_s      = done;
    pass_s      = pass;
    fail_s      = fail;
    timeout_s   = timeout;
    exit_code_s = exit_code;
    cycle_cnt_s = cycle_cnt;
    led_snap_s  = led_snap;
    if (go_hold_s) begin
      state_s     = ST_HOLD;
      hold_cnt_s  = {HOLD_W{1'b0}};
      core_rst_s  = 1'b1;
      done_s      = 1'b0;
      pass_s      = 1'b0;
      fail_s      = 1'b0;
      timeout_s   = 1'b0;
      exit_code_s = {DATA_W{1'b0}};
      cycle_cnt_s = {CNT_W{1'b0}};
      led_snap_s  = {LED_W{1'b0}};
    end else begin
      case (state_r)
        ST_HOLD: begin
          core_rst_s = 1'b1;
          if (restart) begin
            hold_cnt_s = {HOLD_W{1'b0}};
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_s    = ST_RUN;
            hold_cnt_s = {HOLD_W{1'b0}};
            core_rst_s = 1'b0;
          end else begin
            hold_cnt_s = hold_cnt_r + HOLD_ONE;
          end
        end
        ST_RUN: begin
          core_rst_s = 1'b0;
          // Mailbox hit outranks the timeout; cycle_cnt stays at the hit cycle.
          if (hit_s) begin
            state_s    = ST_END;
            core_rst_s = 1'b1;
            done_s     = 1'b1;
            led_snap_s = led_in;
            if (dmem_wdata == DATA_ONE) begin
              pass_s      = 1'b1;
              exit_code_s = {DATA_W{1'b0}};
            end else begin
              fail_s      = 1'b1;
              exit_code_s = dmem_wdata >> 1;
            end
          end else if (cycle_cnt == CNT_LAST) begin
            state_s     = ST_END;
            core_rst_s  = 1'b1;
            done_s      = 1'b1;
            timeout_s   = 1'b1;
            cycle_cnt_s = CNT_MAX;
            led_snap_s  = led_in;
          end else begin
            cycle_cnt_s = cycle_cnt + CNT_ONE;
          end
        end
        ST_END: begin
          core_rst_s = 1'b1;
        end
        default: begin
          state_s     = ST_HOLD;
          hold_cnt_s  = {HOLD_W{1'b0}};
          core_rst_s  = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          fail_s      = 1'b0;
          timeout_s   = 1'b0;
          exit_code_s = {DATA_W{1'b0}};
          cycle_cnt_s = {CNT_W{1'b0}};
          led_snap_s  = {LED_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers; rst_n forces the full hold sequence to start over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HOLD;
      hold_cnt_r <= {HOLD_W{1'b0}};
      core_rst   <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      exit_code  <= {DATA_W{1'b0}};
      cycle_cnt  <= {CNT_W{1'b0}};
      led_snap   <= {LED_W{1'b0}};
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      core_rst   <= core_rst_s;
      done       <= done_s;
      pass       <= pass_s;
      fail       <= fail_s;
      timeout    <= timeout_s;
      exit_code  <= exit_code_s;
      cycle_cnt  <= cycle_cnt_s;
      led_snap   <= led_snap_s;
    end
  end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4, cycles core reset is held after each (re)start; legal range 1 or more.
REQ-002 SHALL have parameter MAX_CYCLES, default 100, run-cycle budget before timeout; legal range 2 or more.
REQ-003 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-004 SHALL have parameter DATA_W, default 32, data-memory write-data width.
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, end-of-test mailbox address.
REQ-006 SHALL have parameter LED_W, default 4, LED bus width.
REQ-007 SHALL have derived width CNT_W = $clog2(MAX_CYCLES+1).
REQ-008 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port restart  input  1  one-cycle request to rerun the test.
REQ-011 SHALL have port dmem_we  input  1  core data-memory write strobe.
REQ-012 SHALL have port dmem_addr  input  ADDR_W  core write address.
REQ-013 SHALL have port dmem_wdata  input  DATA_W  core write data.
REQ-014 SHALL have port led_in  input  LED_W  core LED outputs.
REQ-015 SHALL have port core_rst  output  1  active-high synchronous reset to the core.
REQ-016 SHALL have port done, pass, fail, timeout  output  1 each  sticky run-status flags.
REQ-017 SHALL have port exit_code  output  DATA_W  failure code (mailbox value >> 1).
REQ-018 SHALL have port cycle_cnt  output  CNT_W  run cycles elapsed.
REQ-019 SHALL have port led_snap  output  LED_W  led_in captured at run end.

Function
REQ-020 SHALL implement FSM with states HOLD, RUN, END; all outputs registered.
REQ-021 SHALL, in HOLD, drive core_rst=1 and count RST_CYCLES cycles, then move to RUN; core_rst deasserts the first cycle in RUN.
REQ-022 SHALL, in RUN, drive core_rst=0 and increment cycle_cnt by 1 each cycle.
REQ-023 SHALL treat a RUN cycle with dmem_we=1, dmem_addr==TOHOST_ADDR and dmem_wdata!=0 as a mailbox hit; writes of 0 or to other addresses are ignored.
REQ-024 SHALL, on a mailbox hit with wdata==1, move to END with done=1, pass=1, exit_code=0, registered one cycle after the hit.
REQ-025 SHALL, on a mailbox hit with wdata!=1, move to END with done=1, fail=1, exit_code=wdata>>1.
REQ-026 SHALL, when cycle_cnt==MAX_CYCLES-1 in RUN with no hit, move to END with done=1, timeout=1, cycle_cnt=MAX_CYCLES.
REQ-027 SHALL give a mailbox hit priority over timeout in the same cycle.
REQ-028 SHALL, on entering END, capture led_in into led_snap and hold cycle_cnt frozen (never exceeds MAX_CYCLES).
REQ-029 SHALL, in END, drive core_rst=1 and hold all flags, exit_code, led_snap until restart or rst_n.
REQ-030 SHALL, on restart in RUN or END, clear done/pass/fail/timeout/exit_code/cycle_cnt/led_snap and enter HOLD next cycle; restart in HOLD restarts the hold count.
REQ-031 SHALL keep exactly one of pass/fail/timeout set whenever done=1 and none when done=0.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronously), force state HOLD, core_rst=1, hold counter 0, cycle_cnt 0, all flags 0, exit_code 0, led_snap 0.
REQ-033 SHALL, on rst_n assertion mid-RUN or END, abandon the run and repeat the full RST_CYCLES hold after release.

Verification
REQ-034 SHALL verify reset release: rst_n low->high -> core_rst=1 for exactly 4 cycles, then 0; cycle_cnt counts 0,1,2...
REQ-035 SHALL verify pass: write 1 to 0x1000 at run cycle 20, led_in=4'b1010 -> done=1, pass=1, cycle_cnt=20, led_snap=4'b1010, core_rst=1.
REQ-036 SHALL verify fail: write 0x0000_0007 to 0x1000 -> fail=1, exit_code=3; write to 0x1004 or value 0 earlier -> ignored.
REQ-037 SHALL verify timeout and tie: no write -> timeout=1, cycle_cnt=100; write 1 to 0x1000 on cycle 99 -> pass=1, timeout=0.
REQ-038 SHALL verify restart/reset: restart pulse in END -> flags cleared, 4-cycle hold, new run; rst_n low mid-RUN -> all outputs at reset values immediately.
